tmds_channel_encoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 24 ++
 rtl/tmds_channel_encoder_qm.sv | 44 ++++
 rtl/tmds_channel_encoder.sv | 104 ++++++++++
 tb/tb_tmds_channel_encoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS channel definitions: control tokens, symbol width, disparity type
// and the 8-bit popcount used by both encoder stages.
package tmds_pkg;

   localparam int TMDS_W     = 10;
   localparam int DISP_W_DEF = 5;

   localparam logic [TMDS_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [TMDS_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [TMDS_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [TMDS_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

   typedef logic signed [DISP_W_DEF-1:0] disp_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_channel_encoder_qm.sv
// Stage 1 of the TMDS encoder: transition-minimising q_m word plus the
// registered de/ctrl that travel alongside it.
module tmds_qm_stage
   import tmds_pkg::*;
(
   input  logic       i_clk_pxl,
   input  logic       i_reset,
   input  logic [7:0] data,
   input  logic [1:0] ctrl,
   input  logic       de,
   output logic [8:0] q_m,
   output logic [1:0] ctrl_q,
   output logic       de_q
);

   logic [3:0] n1;
   logic       use_xnor;
   logic [8:0] q_m_next;

   always_comb begin
      n1       = popcount8(data);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
      q_m_next = '0;
      q_m_next[0] = data[0];
      for (int i = 1; i < 8; i++) begin
         q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ data[i]) : (q_m_next[i-1] ^ data[i]);
      end
      q_m_next[8] = ~use_xnor;
   end

   // q_m is forced to zero during blanking so undefined pixel data never enters stage 2.
   always_ff @(posedge i_clk_pxl) begin
      if (i_reset) begin
         q_m    <= '0;
         ctrl_q <= 2'b00;
         de_q   <= 1'b0;
      end else begin
         q_m    <= de ? q_m_next : 9'd0;
         ctrl_q <= ctrl;
         de_q   <= de;
      end
   end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS/DVI channel: 8b data + 2b control to 10b DC-balanced symbols.
// Define TMDS_INPUT_REG_EN to add an input register stage (latency 3 instead of 2).
module tmds_channel_encoder
   import tmds_pkg::*;
#(
   parameter int DISP_W = 5
) (
   input  logic              i_clk_pxl,
   input  logic              i_reset,
   input  logic [7:0]        i_data,
   input  logic [1:0]        i_ctrl,
   input  logic              i_de,
   output logic [TMDS_W-1:0] o_tmds
);

`ifdef TMDS_INPUT_REG_EN
   localparam int LATENCY = 3;
`else
   localparam int LATENCY = 2;
`endif

   localparam logic signed [DISP_W-1:0] DISP_TWO = DISP_W'(2);

   logic [7:0] data_s;
   logic [1:0] ctrl_s;
   logic       de_s;

   if (LATENCY == 3) begin : g_in_reg
      always_ff @(posedge i_clk_pxl) begin
         if (i_reset) begin
            data_s <= 8'd0;
            ctrl_s <= 2'b00;
            de_s   <= 1'b0;
         end else begin
            data_s <= i_data;
            ctrl_s <= i_ctrl;
            de_s   <= i_de;
         end
      end
   end else begin : g_no_in_reg
      assign data_s = i_data;
      assign ctrl_s = i_ctrl;
      assign de_s   = i_de;
   end

   logic [8:0] q_m;
   logic [1:0] ctrl_q;
   logic       de_q;

   tmds_qm_stage u_qm (
      .i_clk_pxl (i_clk_pxl),
      .i_reset   (i_reset),
      .data      (data_s),
      .ctrl      (ctrl_s),
      .de        (de_s),
      .q_m       (q_m),
      .ctrl_q    (ctrl_q),
      .de_q      (de_q)
   );

   logic [3:0]               n1q;
   logic [3:0]               n0q;
   logic signed [DISP_W-1:0] diff;
   logic signed [DISP_W-1:0] cnt;
   logic                     cnt_zero;
   logic                     balanced;
   logic                     invert;

   // diff is N1-N0 of q_m[7:0], both counts zero-extended into the signed domain.
   always_comb begin
      n1q      = popcount8(q_m[7:0]);
      n0q      = 4'd8 - n1q;
      diff     = $signed({{(DISP_W-4){1'b0}}, n1q}) - $signed({{(DISP_W-4){1'b0}}, n0q});
      cnt_zero = (cnt == '0);
      balanced = (n1q == n0q);
      invert   = (!cnt[DISP_W-1] && !cnt_zero && (n1q > n0q)) ||
                 (cnt[DISP_W-1] && (n0q > n1q));
   end

   always_ff @(posedge i_clk_pxl) begin
      if (i_reset) begin
         o_tmds <= CTRL_TOKEN_00;
         cnt    <= '0;
      end else if (!de_q) begin
         cnt <= '0;
         case (ctrl_q)
            2'b00:   o_tmds <= CTRL_TOKEN_00;
            2'b01:   o_tmds <= CTRL_TOKEN_01;
            2'b10:   o_tmds <= CTRL_TOKEN_10;
            default: o_tmds <= CTRL_TOKEN_11;
         endcase
      end else if (cnt_zero || balanced) begin
         o_tmds <= {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
         cnt    <= q_m[8] ? (cnt + diff) : (cnt - diff);
      end else if (invert) begin
         o_tmds <= {1'b1, q_m[8], ~q_m[7:0]};
         cnt    <= cnt - diff + (q_m[8] ? DISP_TWO : '0);
      end else begin
         o_tmds <= {1'b0, q_m[8], q_m[7:0]};
         cnt    <= cnt + diff - (q_m[8] ? '0 : DISP_TWO);
      end
   end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: directed token/data vectors with
// hand-computed symbols, a long random data run against a reference model, and mid-stream reset.
module tb_tmds_channel_encoder;

   localparam logic [9:0] TOK00 = 10'b1101010100;
   localparam logic [9:0] TOK01 = 10'b0010101011;
   localparam logic [9:0] TOK10 = 10'b0101010100;
   localparam logic [9:0] TOK11 = 10'b1010101011;

   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic [7:0] i_data = 8'd0;
   logic [1:0] i_ctrl = 2'b00;
   logic       i_de = 1'b0;
   logic [9:0] o_tmds;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   tmds_channel_encoder dut (
      .i_clk_pxl (clk),
      .i_reset   (i_reset),
      .i_data    (i_data),
      .i_ctrl    (i_ctrl),
      .i_de      (i_de),
      .o_tmds    (o_tmds)
   );

   // ---------------- scoreboard state ----------------
   logic [10:0] exp_q[$];   // {de, symbol}
   logic        issue = 1'b0;
   logic [7:0]  hist = 8'd0;
   int          lat = 2;
   int          checks = 0;
   int          errors = 0;
   int          m_cnt = 0;
   int          run_disp = 0;

   initial lat = dut.LATENCY;

   always @(posedge clk) hist <= {hist[6:0], issue};

   // ---------------- reference model ----------------
   function automatic logic [9:0] model_step(input logic [7:0] d, input logic de, input logic [1:0] c);
      logic [8:0] qm;
      int         ones, n1, n0;
      logic       xn;
      logic [9:0] r;
      if (!de) begin
         m_cnt = 0;
         case (c)
            2'b00:   r = TOK00;
            2'b01:   r = TOK01;
            2'b10:   r = TOK10;
            default: r = TOK11;
         endcase
         return r;
      end
      ones = $countones(d);
      xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~xn;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (m_cnt == 0 || n1 == n0) begin
         r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         m_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
      end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
         r = {1'b1, qm[8], ~qm[7:0]};
         m_cnt += 2 * int'(qm[8]) + (n0 - n1);
      end else begin
         r = {1'b0, qm[8], qm[7:0]};
         m_cnt += -2 * int'(!qm[8]) + (n1 - n0);
      end
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_exp(input logic [7:0] d, input logic de, input logic [1:0] c,
                            input logic [9:0] exp_sym);
      logic [9:0] unused_sym;
      @(negedge clk); #1;
      i_reset = 1'b0;
      i_data = d; i_de = de; i_ctrl = c;
      issue = 1'b1;
      unused_sym = model_step(d, de, c);
      exp_q.push_back({de, exp_sym});
   endtask

   task automatic drive_model(input logic [7:0] d, input logic de, input logic [1:0] c);
      logic [9:0] sym;
      @(negedge clk); #1;
      i_reset = 1'b0;
      i_data = d; i_de = de; i_ctrl = c;
      issue = 1'b1;
      sym = model_step(d, de, c);
      exp_q.push_back({de, sym});
   endtask

   // Reset flushes everything in flight, so pending expectations become ctrl-00 tokens.
   task automatic do_reset(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk); #1;
         i_reset = 1'b1;
         i_de = 1'b1;
         i_data = 8'($urandom_range(0, 255));
         i_ctrl = 2'b00;
         issue = 1'b1;
         foreach (exp_q[i]) exp_q[i] = {1'b0, TOK00};
         exp_q.push_back({1'b0, TOK00});
         m_cnt = 0;
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (hist[lat-1]) begin
         logic [10:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL underflow: output 0x%03h with no expected entry", o_tmds);
         end else begin
            e = exp_q.pop_front();
            if (o_tmds !== e[9:0]) begin
               errors++;
               $display("FAIL symbol @%0t: got %b expected %b", $time, o_tmds, e[9:0]);
            end
            if (e[10]) begin
               run_disp += 2 * $countones(o_tmds) - 10;
               checks++;
               if (run_disp > 16 || run_disp < -16) begin
                  errors++;
                  $display("FAIL disparity_bound @%0t: running %0d limit 16", $time, run_disp);
               end
            end else begin
               run_disp = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      do_reset(3);

      repeat (3) drive_exp(8'h00, 1'b0, 2'b00, TOK00);
      drive_exp(8'hxx, 1'b0, 2'b01, TOK01);
      drive_exp(8'hxx, 1'b0, 2'b10, TOK10);
      drive_exp(8'hxx, 1'b0, 2'b11, TOK11);

      drive_exp(8'h00, 1'b1, 2'b00, 10'b0100000000);
      drive_exp(8'h00, 1'b1, 2'b00, 10'b1111111111);
      drive_exp(8'h00, 1'b1, 2'b00, 10'b0100000000);
      drive_exp(8'hxx, 1'b0, 2'b00, TOK00);
      drive_exp(8'hFF, 1'b1, 2'b00, 10'b1000000000);
      drive_exp(8'h5A, 1'b0, 2'b00, TOK00);
      drive_exp(8'h00, 1'b1, 2'b00, 10'b0100000000);
      drive_exp(8'hxx, 1'b0, 2'b11, TOK11);

      for (int i = 0; i < 10000; i++) drive_model(8'($urandom_range(0, 255)), 1'b1, 2'b00);
      drive_model(8'h00, 1'b0, 2'b01);

      for (int i = 0; i < 6; i++) drive_model(8'($urandom_range(0, 255)), 1'b1, 2'b00);
      do_reset(1);
      for (int i = 0; i < 24; i++) drive_model(8'($urandom_range(0, 255)), 1'b1, 2'b00);
      drive_model(8'h00, 1'b0, 2'b00);

      @(negedge clk); #1;
      issue = 1'b0;
      repeat (lat + 4) @(negedge clk);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
